cdc_handshake_tx: RTL and testbench

- Sending side of a four-phase req/ack clock-domain crossing.
- Accepts a data word from local logic, holds it stable on `data_out`, and raises `req_out` toward a receiver in another clock domain.
- Waits for the receiver's asynchronous `ack_in`, which passes through an internal multi-flop synchronizer, then completes the return-to-zero phase.
- Sits at the boundary wherever CPU-domain data (e.g. memory-mapped I/O writes) must reach a slower or asynchronous peripheral clock.

---
 rtl/cdc_handshake_tx_if.sv | 33 +++
 rtl/cdc_handshake_tx.sv | 112 +++++++++++
 tb/tb_cdc_handshake_tx.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdc_handshake_tx_if.sv
// ============================================================================
// Module   : cdc_handshake_tx_if
// Purpose  : Local-side and remote-side signal bundle of the four-phase CDC sender.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cdc_handshake_tx_if #(
    parameter int DATA_W = 8
);
    logic              send_valid;
    logic [DATA_W-1:0] send_data;
    logic              send_ready;
    logic              send_done;
    logic              timeout_err;
    logic              err_clr;
    logic              req_out;
    logic [DATA_W-1:0] data_out;
    logic              ack_in;

    // master is the sender block itself; slave is local logic plus remote peer
    modport master (
        input  send_valid, send_data, err_clr, ack_in,
        output send_ready, send_done, timeout_err, req_out, data_out
    );

    modport slave (
        output send_valid, send_data, err_clr, ack_in,
        input  send_ready, send_done, timeout_err, req_out, data_out
    );
endinterface

`default_nettype wire

// File: rtl/cdc_handshake_tx.sv
// ============================================================================
// Module   : cdc_handshake_tx
// Purpose  : Sending side of a four-phase req/ack clock-domain crossing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdc_handshake_tx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024,
    parameter int CNT_W       = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    cdc_handshake_tx_if.master   bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETUP    = 2'd1,
        REQ_WAIT = 2'd2,
        REL_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_TMO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    state_t                 state_q;
    logic                   req_q;
    logic [DATA_W-1:0]      data_q;
    logic                   done_q;
    logic                   err_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [SYNC_STAGES-1:0] sync_q;

    logic w_ack_s;
    logic w_ready;
    logic w_tmo;

    assign w_ack_s = sync_q[SYNC_STAGES-1];
    // A stale ack left over from an aborted transfer must block new accepts
    assign w_ready = (state_q == IDLE) && !w_ack_s;
    assign w_tmo   = (TIMEOUT != 0) && (cnt_q == c_TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            sync_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.ack_in};
            done_q <= 1'b0;
            if (bus.err_clr) begin
                err_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (bus.send_valid && w_ready) begin
                        data_q  <= bus.send_data;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    req_q   <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= REQ_WAIT;
                end
                REQ_WAIT: begin
                    // The exit condition takes priority over a coincident timeout
                    if (w_ack_s) begin
                        req_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= REL_WAIT;
                    end else if (w_tmo) begin
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + c_CNT_ONE;
                    end
                end
                REL_WAIT: begin
                    if (!w_ack_s) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else if (w_tmo) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + c_CNT_ONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.send_ready  = w_ready;
    assign bus.send_done   = done_q;
    assign bus.timeout_err = err_q;
    assign bus.req_out     = req_q;
    assign bus.data_out    = data_q;

endmodule

`default_nettype wire

// File: tb/tb_cdc_handshake_tx.sv
// ============================================================================
// Module   : tb_cdc_handshake_tx
// Purpose  : Directed bench with remote responder and in-order data scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cdc_handshake_tx;

    localparam int DATA_W  = 8;
    localparam int SYNC    = 2;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 5;

    logic clk;
    logic rst;

    cdc_handshake_tx_if #(.DATA_W(DATA_W)) bus ();

    cdc_handshake_tx #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC),
        .TIMEOUT     (TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec    = 0;
    int n_err    = 0;
    int done_cnt = 0;
    int b2b      = 0;
    int rx_cnt   = 0;
    bit acc      = 1'b0;
    bit resp_en  = 1'b0;
    bit man_ack  = 1'b0;
    logic [DATA_W-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs are stable from the negedge to the next posedge, so an accept is
    // predicted here and its word pushed before the edge that takes it.
    task automatic tick();
        acc = 1'b0;
        if (!rst && bus.send_valid && bus.send_ready) begin
            acc = 1'b1;
            exp_q.push_back(bus.send_data);
            if (bus.send_done === 1'b1) b2b++;
        end
        @(negedge clk);
        if (bus.send_done === 1'b1) done_cnt++;
    endtask

    // Remote responder: ack 3 cycles after seeing req high, release 3 after req low
    initial begin
        int hi = 0;
        int lo = 0;
        bus.ack_in = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!resp_en) begin
                bus.ack_in = man_ack;
                hi = 0;
                lo = 0;
            end else if (!bus.ack_in) begin
                hi = bus.req_out ? hi + 1 : 0;
                if (hi == 3) begin
                    hi = 0;
                    bus.ack_in = 1'b1;
                    rx_cnt++;
                    chk("rx_avail", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) chk("rx_data", 32'(bus.data_out), 32'(exp_q.pop_front()));
                end
            end else begin
                lo = !bus.req_out ? lo + 1 : 0;
                if (lo == 3) begin
                    lo = 0;
                    bus.ack_in = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        int base;
        int rx0;
        logic [DATA_W-1:0] x;

        rst            = 1'b1;
        bus.send_valid = 1'b0;
        bus.send_data  = '0;
        bus.err_clr    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_req",   32'(bus.req_out),     32'd0);
        chk("rst_data",  32'(bus.data_out),    32'd0);
        chk("rst_done",  32'(bus.send_done),   32'd0);
        chk("rst_err",   32'(bus.timeout_err), 32'd0);
        chk("rst_ready", 32'(bus.send_ready),  32'd1);

        // Basic transfer of 0xA5
        resp_en = 1'b1;
        base = done_cnt;
        bus.send_valid = 1'b1;
        bus.send_data  = 8'hA5;
        tick();
        chk("b1_data_accept", 32'(bus.data_out),   32'hA5);
        chk("b1_req_setup",   32'(bus.req_out),    32'd0);
        chk("b1_ready_busy",  32'(bus.send_ready), 32'd0);
        bus.send_valid = 1'b0;
        tick();
        chk("b1_req_rise", 32'(bus.req_out), 32'd1);
        n = 0;
        while (bus.ack_in !== 1'b1 && n < 30) begin tick(); n++; end
        chk("b1_ack_seen", 32'(bus.ack_in), 32'd1);
        n = 0;
        while (bus.req_out !== 1'b0 && n < 30) begin
            chk("b1_data_hold", 32'(bus.data_out), 32'hA5);
            tick();
            n++;
        end
        // ack_in is sampled at the next edge, then SYNC edges later ack_s drives the FSM
        chk("b1_req_fall_lat", 32'(n), 32'(SYNC + 1));
        n = 0;
        while (bus.send_done !== 1'b1 && n < 30) begin
            chk("b1_data_rel", 32'(bus.data_out), 32'hA5);
            tick();
            n++;
        end
        chk("b1_done_count", 32'(done_cnt - base), 32'd1);
        chk("b1_ready_done", 32'(bus.send_ready), 32'd1);
        tick();
        chk("b1_done_pulse", 32'(bus.send_done),  32'd0);
        chk("b1_ready_idle", 32'(bus.send_ready), 32'd1);

        // Data stability with send_data toggling every cycle
        bus.send_valid = 1'b1;
        bus.send_data  = 8'h3C;
        tick();
        n = 0;
        while (bus.send_done !== 1'b1 && n < 40) begin
            chk("stab_hold", 32'(bus.data_out), 32'h3C);
            bus.send_data = bus.send_data + 8'h29;
            tick();
            n++;
        end
        chk("stab_done_data", 32'(bus.data_out), 32'h3C);
        x = bus.send_data;
        tick();
        bus.send_valid = 1'b0;
        chk("stab_next_capture", 32'(bus.data_out), 32'(x));
        n = 0;
        while (bus.send_done !== 1'b1 && n < 40) begin tick(); n++; end
        chk("stab_next_done", 32'(bus.send_done), 32'd1);
        chk("stab_sb_empty", 32'(exp_q.size()), 32'd0);

        // Timeout with ack held low
        resp_en = 1'b0;
        man_ack = 1'b0;
        base = done_cnt;
        tick();
        bus.send_valid = 1'b1;
        bus.send_data  = 8'h5A;
        tick();
        bus.send_valid = 1'b0;
        tick();
        chk("to_req_rise", 32'(bus.req_out), 32'd1);
        n = 0;
        while (bus.req_out !== 1'b0 && n < 40) begin tick(); n++; end
        chk("to_latency", 32'(n), 32'(TIMEOUT));
        chk("to_err_set", 32'(bus.timeout_err), 32'd1);
        chk("to_ready",   32'(bus.send_ready),  32'd1);
        tick();
        tick();
        chk("to_no_done", 32'(done_cnt - base), 32'd0);
        exp_q.delete();
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("to_err_clr", 32'(bus.timeout_err), 32'd0);

        // Stale ack arrives late after the abort
        man_ack = 1'b1;
        tick();
        tick();
        chk("stale_ready_pre", 32'(bus.send_ready), 32'd1);
        tick();
        chk("stale_ready_block", 32'(bus.send_ready), 32'd0);
        bus.send_valid = 1'b1;
        bus.send_data  = 8'hEE;
        tick();
        tick();
        tick();
        chk("stale_ready_held", 32'(bus.send_ready), 32'd0);
        chk("stale_no_accept",  32'(bus.data_out),   32'h5A);
        chk("stale_req_low",    32'(bus.req_out),    32'd0);
        bus.send_valid = 1'b0;
        man_ack = 1'b0;
        tick();
        chk("stale_ack_fell", 32'(bus.ack_in),     32'd0);
        chk("stale_ready_0a", 32'(bus.send_ready), 32'd0);
        tick();
        chk("stale_ready_0b", 32'(bus.send_ready), 32'd0);
        tick();
        chk("stale_ready_back", 32'(bus.send_ready), 32'd1);

        // Reset while waiting for ack
        resp_en = 1'b1;
        bus.send_valid = 1'b1;
        bus.send_data  = 8'hC3;
        tick();
        bus.send_valid = 1'b0;
        tick();
        tick();
        chk("mrst_req_before", 32'(bus.req_out), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_req",   32'(bus.req_out),    32'd0);
        chk("mrst_data",  32'(bus.data_out),   32'd0);
        chk("mrst_ready", 32'(bus.send_ready), 32'd1);
        exp_q.delete();
        tick();

        // Back-to-back words 0x01..0x04 with send_valid held high
        base = done_cnt;
        rx0  = rx_cnt;
        b2b  = 0;
        bus.send_data  = 8'h01;
        bus.send_valid = 1'b1;
        k = 0;
        n = 0;
        while (k < 4 && n < 300) begin
            tick();
            n++;
            if (acc) begin
                k++;
                bus.send_data = bus.send_data + 8'h01;
            end
        end
        bus.send_valid = 1'b0;
        chk("b2b_accepts", 32'(k), 32'd4);
        n = 0;
        while ((done_cnt - base) < 4 && n < 100) begin tick(); n++; end
        for (int i = 0; i < 10; i++) tick();
        chk("b2b_done_count", 32'(done_cnt - base), 32'd4);
        chk("b2b_rx_count",   32'(rx_cnt - rx0),    32'd4);
        chk("b2b_sb_empty",   32'(exp_q.size()),    32'd0);
        chk("b2b_same_cycle", 32'(b2b),             32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
